// File: rtl/prng_range_pkg.sv
// Shared types and helpers for the uniform-range sampler behind the
// xoroshiro64* PRNG stage.
package prng_range_pkg;

    // Sequencing of the PRNG: load seed, burn warm-up words, then run.
    typedef enum logic [1:0] {
        SEED = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int REJECT_CNT_W = 16;

    // Wide enough to hold any bit count or shift for widths up to 32.
    localparam int BITS_W = 6;

    // Right-shift applied to the top WIDTH bits of a raw word so that the
    // candidate spans exactly the smallest power-of-two range covering the
    // limit. A zero limit selects the full 2^WIDTH range (no shift).
    function automatic logic [BITS_W-1:0] calc_shift(
        input logic              limit_zero,
        input logic [BITS_W-1:0] bits,
        input int unsigned       width
    );
        if (limit_zero) begin
            return '0;
        end
        return BITS_W'(width) - bits;
    endfunction

endpackage

// File: rtl/ceil_log2.sv
// Combinational ceil(log2(value)) priority encoder.
// value 1 -> 0, value >= 2 -> ceil(log2(value)); value 0 wraps to WIDTH,
// which is exactly the bit count of the full 2^WIDTH range.
module ceil_log2
    import prng_range_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]  value,
    output logic [BITS_W-1:0] bits
);

    logic [WIDTH-1:0] value_m1;

    // Bit count of (value - 1): position of its highest set bit plus one.
    always_comb begin
        value_m1 = value - WIDTH'(1);
        bits     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (value_m1[i]) begin
                bits = BITS_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/prng_uniform_range.sv
// Mask-and-reject sampler: turns 32-bit PRNG words into unbiased uniform
// integers in [0, limit) and presents them on a valid/ready output.
module prng_uniform_range
    import prng_range_pkg::*;
#(
    parameter int          WIDTH   = 16,
    parameter logic [31:0] SEED_S0 = 32'h0000_0001,
    parameter logic [31:0] SEED_S1 = 32'h9E37_79B9,
    parameter int          WARMUP  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_limitWr,
    input  logic [WIDTH-1:0]        i_limit,
    output logic                    o_prngCg,
    output logic                    o_seedValid,
    output logic [31:0]             o_seedS0,
    output logic [31:0]             o_seedS1,
    input  logic [31:0]             i_prngResult,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [WIDTH-1:0]        o_data,
    output logic [REJECT_CNT_W-1:0] o_rejectCount
);

    state_t             state;
    logic [7:0]         warm_cnt;
    logic [WIDTH-1:0]   limit_q;
    logic [BITS_W-1:0]  shift_q;
    logic               fresh_q;

    logic [BITS_W-1:0]  new_bits;
    logic [31:0]        cand32;
    logic               accept;
    logic               can_load;
    logic               prng_cg;

    ceil_log2 #(
        .WIDTH (WIDTH)
    ) u_ceil_log2 (
        .value (i_limit),
        .bits  (new_bits)
    );

    assign o_seedS0 = SEED_S0;
    assign o_seedS1 = SEED_S1;

    // Advance the PRNG while seeding/warming, and in RUN only when the
    // output slot is free or being emptied this cycle.
    always_comb begin
        prng_cg = 1'b0;
        case (state)
            SEED:    prng_cg = 1'b1;
            WARM:    prng_cg = 1'b1;
            RUN:     prng_cg = !o_valid || i_ready;
            default: prng_cg = 1'b0;
        endcase
    end

    assign o_prngCg    = !i_rst && prng_cg;
    assign o_seedValid = !i_rst && (state == SEED);

    // Candidate from the top WIDTH bits only (the high bits of xoroshiro64*
    // are the strongest); kept 32 bits wide so the compare sees every bit.
    assign cand32   = (i_prngResult >> (32 - WIDTH)) >> shift_q;
    assign accept   = (limit_q == '0) || (cand32 < 32'(limit_q));
    assign can_load = !o_valid || i_ready;

    // Seed / warm-up / run sequencing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= SEED;
            warm_cnt <= '0;
        end else begin
            case (state)
                SEED: begin
                    state    <= WARM;
                    warm_cnt <= '0;
                end
                WARM: begin
                    if (warm_cnt == 8'(WARMUP - 1)) begin
                        state <= RUN;
                    end else begin
                        warm_cnt <= warm_cnt + 8'd1;
                    end
                end
                RUN:     state <= RUN;
                default: state <= SEED;
            endcase
        end
    end

    // Limit registers, fresh-word tracking, sample output and reject count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            limit_q       <= '0;
            shift_q       <= '0;
            fresh_q       <= 1'b0;
            o_valid       <= 1'b0;
            o_data        <= '0;
            o_rejectCount <= '0;
        end else begin
            // A word is new only in the cycle after a RUN-state draw.
            fresh_q <= prng_cg && (state == RUN);

            if (i_limitWr) begin
                // Any word in this cycle was drawn under the old limit; drop it.
                limit_q       <= i_limit;
                shift_q       <= calc_shift(i_limit == '0, new_bits, WIDTH);
                o_valid       <= 1'b0;
                o_rejectCount <= '0;
            end else begin
                if (fresh_q && accept && can_load) begin
                    o_data  <= cand32[WIDTH-1:0];
                    o_valid <= 1'b1;
                end else if (o_valid && i_ready) begin
                    o_valid <= 1'b0;
                end

                if (fresh_q && !accept && (o_rejectCount != '1)) begin
                    o_rejectCount <= o_rejectCount + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prng_uniform_range.sv
// Directed bench for prng_uniform_range with a cycle-level reference model.
module tb_prng_uniform_range;

    localparam int W      = 16;
    localparam int WARMUP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          limit_wr;
    logic [W-1:0]  limit;
    logic          prng_cg;
    logic          seed_valid;
    logic [31:0]   seed_s0;
    logic [31:0]   seed_s1;
    logic [31:0]   word;
    logic          valid;
    logic          ready;
    logic [W-1:0]  data;
    logic [15:0]   rej_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prng_uniform_range #(
        .WIDTH   (W),
        .SEED_S0 (32'h0000_0001),
        .SEED_S1 (32'h9E37_79B9),
        .WARMUP  (WARMUP)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_limitWr     (limit_wr),
        .i_limit       (limit),
        .o_prngCg      (prng_cg),
        .o_seedValid   (seed_valid),
        .o_seedS0      (seed_s0),
        .o_seedS1      (seed_s1),
        .i_prngResult  (word),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_data        (data),
        .o_rejectCount (rej_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_ok = 1'b0;
    int          m_cycle;
    bit          m_valid;
    bit          m_fresh;
    int unsigned m_data;
    int unsigned m_limit;
    int unsigned m_rej;

    // Smallest power-of-two range covering the limit, as a shift of the top W bits.
    function automatic int unsigned range_shift(input int unsigned lim);
        int unsigned b;
        if (lim == 0) return 0;
        b = 0;
        while ((32'd1 << b) < lim) b++;
        return W - b;
    endfunction

    function automatic bit model_cg();
        return (m_cycle <= WARMUP) || !m_valid || (ready == 1'b1);
    endfunction

    always @(posedge clk) begin
        int unsigned cand;
        bit          draw;
        if (rst === 1'b1) begin
            m_ok    = 1'b1;
            m_cycle = 0;
            m_valid = 1'b0;
            m_fresh = 1'b0;
            m_data  = 0;
            m_limit = 0;
            m_rej   = 0;
        end else if (m_ok) begin
            draw = model_cg() && (m_cycle > WARMUP);
            if (limit_wr) begin
                m_limit = limit;
                m_valid = 1'b0;
                m_rej   = 0;
            end else begin
                cand = (word >> (32 - W)) / (32'd1 << range_shift(m_limit));
                if (m_fresh && (m_limit == 0 || cand < m_limit) && (!m_valid || ready)) begin
                    m_data  = cand;
                    m_valid = 1'b1;
                end else if (m_valid && ready) begin
                    m_valid = 1'b0;
                end
                if (m_fresh && !(m_limit == 0 || cand < m_limit) && m_rej < 65535)
                    m_rej++;
            end
            m_fresh = draw;
            if (m_cycle < 1000) m_cycle++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_seed_valid", 32'(seed_valid), 32'((rst == 1'b0) && (m_cycle == 0)));
            chk("m_prng_cg",    32'(prng_cg),    32'((rst == 1'b0) && model_cg()));
            chk("m_valid",      32'(valid),      32'(m_valid));
            chk("m_data",       32'(data),       m_data);
            chk("m_reject_cnt", 32'(rej_cnt),    m_rej);
            chk("m_seed_s0",    seed_s0,         32'h0000_0001);
            chk("m_seed_s1",    seed_s1,         32'h9E37_79B9);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_limit(input logic [W-1:0] lim);
        limit_wr = 1'b1;
        limit    = lim;
        step();
        limit_wr = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        limit_wr = 1'b0;
        limit    = '0;
        ready    = 1'b1;
        word     = 32'h1234_5678;
        step();
        step();
        chk("rst_valid",      32'(valid),      32'd0);
        chk("rst_data",       32'(data),       32'd0);
        chk("rst_reject",     32'(rej_cnt),    32'd0);
        chk("rst_seed_valid", 32'(seed_valid), 32'd0);
        chk("rst_cg",         32'(prng_cg),    32'd0);

        // Seed cycle, warm-up, then RUN
        rst = 1'b0;
        #1;
        chk("seed_strobe", 32'(seed_valid), 32'd1);
        chk("seed_cg",     32'(prng_cg),    32'd1);
        chk("seed_s0",     seed_s0,         32'h0000_0001);
        chk("seed_s1",     seed_s1,         32'h9E37_79B9);
        for (int i = 1; i <= WARMUP; i++) begin
            step();
            chk("warm_cg",    32'(prng_cg),    32'd1);
            chk("warm_seed",  32'(seed_valid), 32'd0);
            chk("warm_valid", 32'(valid),      32'd0);
        end
        step();
        chk("run_entry_valid", 32'(valid), 32'd0);
        step();
        chk("run_first_draw_valid", 32'(valid), 32'd0);
        step();
        chk("run_first_valid", 32'(valid), 32'd1);
        chk("run_first_data",  32'(data),  32'h1234);

        // limit=10: accept 3, then reject 15
        write_limit(16'd10);
        chk("lim10_clr_valid", 32'(valid),   32'd0);
        chk("lim10_clr_rej",   32'(rej_cnt), 32'd0);
        word = 32'h3000_0000;
        step();
        chk("lim10_data",  32'(data),  32'd3);
        chk("lim10_valid", 32'(valid), 32'd1);
        word = 32'hF000_0000;
        step();
        chk("lim10_rej",         32'(rej_cnt), 32'd1);
        chk("lim10_no_sample",   32'(valid),   32'd0);
        chk("lim10_data_hold",   32'(data),    32'd3);

        // limit=0 full range, limit=1 always zero
        write_limit(16'd0);
        word = 32'hABCD_1234;
        step();
        chk("lim0_data",  32'(data),  32'hABCD);
        chk("lim0_valid", 32'(valid), 32'd1);
        write_limit(16'd1);
        word = 32'hFFFF_FFFF;
        step();
        chk("lim1_data",  32'(data),  32'd0);
        chk("lim1_valid", 32'(valid), 32'd1);

        // Backpressure
        write_limit(16'd0);
        word = 32'h1111_0000;
        step();
        chk("bp_first", 32'(data), 32'h1111);
        ready = 1'b0;
        word  = 32'h2222_0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_cg",    32'(prng_cg), 32'd0);
            chk("bp_hold",  32'(data),    32'h1111);
            chk("bp_valid", 32'(valid),   32'd1);
        end
        ready = 1'b1;
        word  = 32'h3333_0000;
        step();
        chk("bp_release_gap", 32'(valid), 32'd0);
        step();
        chk("bp_release_valid", 32'(valid), 32'd1);
        chk("bp_release_data",  32'(data),  32'h3333);

        // Limit write while holding a sample with 7 rejects
        write_limit(16'd10);
        word = 32'hF000_0000;
        for (int i = 0; i < 7; i++) step();
        chk("rej7_count", 32'(rej_cnt), 32'd7);
        ready = 1'b0;
        word  = 32'h5000_0000;
        step();
        chk("rej7_valid", 32'(valid),   32'd1);
        chk("rej7_data",  32'(data),    32'd5);
        chk("rej7_hold",  32'(rej_cnt), 32'd7);
        ready    = 1'b1;
        word     = 32'h0000_0000;
        write_limit(16'd2);
        chk("lw_valid_clr", 32'(valid),   32'd0);
        chk("lw_rej_clr",   32'(rej_cnt), 32'd0);
        chk("lw_data_keep", 32'(data),    32'd5);
        word = 32'h8000_0000;
        step();
        chk("lw_new_valid", 32'(valid), 32'd1);
        chk("lw_new_data",  32'(data),  32'd1);

        // Saturating reject count (limit=3, candidate always 3)
        word = 32'hFFFF_FFFF;
        write_limit(16'd3);
        for (int i = 0; i < 70000; i++) step();
        chk("sat_count", 32'(rej_cnt), 32'h0000_FFFF);
        chk("sat_valid", 32'(valid),   32'd0);

        // Mid-stream reset reseeds
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(valid),      32'd0);
        chk("mid_rst_data",  32'(data),       32'd0);
        chk("mid_rst_rej",   32'(rej_cnt),    32'd0);
        chk("mid_rst_cg",    32'(prng_cg),    32'd0);
        chk("mid_rst_seed",  32'(seed_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("reseed_strobe", 32'(seed_valid), 32'd1);
        step();
        chk("reseed_warm_cg", 32'(prng_cg),    32'd1);
        chk("reseed_done",    32'(seed_valid), 32'd0);
        for (int i = 0; i < 8; i++) step();
        chk("reseed_run_data", 32'(data), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prng_uniform_range.md
Name: prng_uniform_range

Overview:
- Downstream consumer of the xoroshiro64* PRNG stage. Drives that stage's clock-gate and seed inputs, and takes its registered 32-bit result.
- Turns raw random words into unbiased uniform integers in [0, limit) by mask-and-reject sampling.
- Presents samples on a valid/ready output; used by stimulus generators and randomized arbiters.

Parameters:
- WIDTH, 16, sample width in bits, 1..32.
- SEED_S0, 32'h0000_0001, seed for PRNG s0, loaded after reset; SEED_S0|SEED_S1 must be nonzero.
- SEED_S1, 32'h9E37_79B9, seed for PRNG s1.
- WARMUP, 4, PRNG advances discarded after seeding, 1..255.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_limitWr  input  1  load new limit (single-cycle pulse)
- i_limit  input  WIDTH  exclusive upper bound; 0 means full 2^WIDTH range
- o_prngCg  output  1  clock-gate enable to PRNG
- o_seedValid  output  1  seed load strobe to PRNG
- o_seedS0  output  32  constant SEED_S0
- o_seedS1  output  32  constant SEED_S1
- i_prngResult  input  32  PRNG registered result
- o_valid  output  1  sample valid
- i_ready  input  1  sample accepted
- o_data  output  WIDTH  sample
- o_rejectCount  output  16  saturating count of rejected words since last limit write or reset

Behaviour:
- Reset (i_clk edge with i_rst=1):
  - state=SEED, limit_q=0, shift_q=0, fresh_q=0, o_valid=0, o_data=0, o_rejectCount=0, warm counter=0.
  - o_prngCg and o_seedValid are 0 while i_rst is high.
- FSM:
  - SEED, one cycle: o_seedValid=1, o_prngCg=1 → WARM.
  - WARM: o_prngCg=1 for WARMUP cycles, words ignored → RUN.
  - RUN: stays until reset. Reset mid-operation returns to SEED and reseeds.
- RUN draw control:
  - o_prngCg = !o_valid || i_ready.
  - fresh_q <= o_prngCg && state==RUN.
  - i_prngResult is a new word only in the cycle after a cg pulse (fresh_q=1). It is never reused.
- Candidate:
  - cand = i_prngResult[31 -: WIDTH] >> shift_q, using the upper bits only.
  - bits = 0 if limit==1; ceil(log2(limit)) if limit≥2; WIDTH if limit==0.
  - shift_q = WIDTH − bits, registered at i_limitWr.
- Accept: limit_q==0 or cand < limit_q.
  - If fresh_q and accept and (!o_valid || i_ready): o_data<=cand, o_valid<=1.
  - If fresh_q and reject: o_rejectCount += 1, saturating at 16'hFFFF.
  - Fresh accepted words arriving while the output is stalled are discarded. This is statistically harmless.
- Handshake:
  - o_valid && i_ready with no new load → o_valid<=0.
  - o_data is stable while o_valid && !i_ready.
  - Latency: fresh word at cycle t → o_valid at t+1. Steady-state throughput is 1 sample/cycle at 100% acceptance.
- i_limitWr (any state):
  - limit_q, shift_q updated; o_valid<=0; o_rejectCount<=0.
  - A fresh word in that cycle is dropped, so the next sample uses the new limit.
  - Simultaneous i_ready is irrelevant.
- limit==1: cand is always 0, always accepted.
- Worst-case acceptance is just above 50% (e.g. limit=2^k+1). No bound on consecutive rejects.

Decomposition:
- Shared package prng_range_pkg:
  - state enum {SEED, WARM, RUN};
  - REJECT_CNT_W=16;
  - a function computing shift from limit and WIDTH.
- One natural sub-module, ceil_log2: combinational priority encoder, WIDTH in, bits out. It is reused elsewhere for range masks.
- Everything else is flat.

Test Plan:
- Reset release with WARMUP=4 → cycle 0 o_seedValid=1 with seeds 0x00000001/0x9E3779B9. Cycles 1–4 o_prngCg=1 with o_valid stays 0. Cycle 5 in RUN.
- WIDTH=16, limit=10 (shift=12), words 0x30000000 then 0xF0000000 → o_data=3 valid, then a reject with o_rejectCount=1 and no new sample.
- limit=0, word 0xABCD1234 → o_data=0xABCD. limit=1, word 0xFFFFFFFF → o_data=0.
- Backpressure: i_ready=0 with o_valid=1 for 5 cycles → o_prngCg=0, o_data held. Raise i_ready → next sample appears 2 cycles later.
- i_limitWr with o_valid=1 and o_rejectCount=7 → next cycle o_valid=0 and count=0, and the next sample obeys the new limit.
- 70000 forced rejects → o_rejectCount saturates at 0xFFFF. Assert i_rst mid-stream → SEED re-entered and outputs cleared.
